// File: rtl/alu_issue_wb.sv
// Issue/writeback stage around a combinational ALU: reads the operands, drives the ALU, and writes back the result and flags.
// Optional feature: `define ALU_IMM_OPB_EN selects in_imm as ALU operand B when instr[0]=1.
module alu_issue_wb #(
  parameter int unsigned DW   = 8,
  parameter int unsigned NREG = 8,
  parameter int unsigned AW   = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [15:0]   in_instr,
  input  logic [DW-1:0] in_imm,
  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_b,
  output logic [3:0]    alu_op,
  input  logic [DW-1:0] alu_res,
  input  logic [7:0]    alu_flag,
  output logic [7:0]    status,
  output logic          done,
  input  logic          dbg_we,
  input  logic [AW-1:0] dbg_addr,
  input  logic [DW-1:0] dbg_wdata,
  output logic [DW-1:0] dbg_rdata
);

  localparam int unsigned IW = 16;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_WB} state_e;

  state_e          state_q, state_d;
  logic [IW-1:0]   instr_q, instr_d;
  logic [DW-1:0]   regs_q [NREG];
  logic [DW-1:0]   regs_d [NREG];
  logic [7:0]      status_q, status_d;
  logic            done_q, done_d;
  logic            ready_q, ready_d;
  logic [DW-1:0]   alu_a_q, alu_a_d;
  logic [DW-1:0]   alu_b_q, alu_b_d;

  logic [AW-1:0]   in_rs1, in_rs2, wb_rd;
  logic            unused_bits;

  assign in_rs1 = AW'(in_instr[8:6]);
  assign in_rs2 = AW'(in_instr[5:3]);
  assign wb_rd  = AW'(instr_q[11:9]);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (in_valid) state_d = S_EXEC;
      S_EXEC:  state_d = S_WB;
      S_WB:    state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs and datapath; operands are sampled at accept since the register
  // file cannot change between accept and the EXEC->WB edge
  always_comb begin
    instr_d  = instr_q;
    regs_d   = regs_q;
    status_d = status_q;
    alu_a_d  = alu_a_q;
    alu_b_d  = alu_b_q;
    done_d   = (state_d == S_WB);
    ready_d  = (state_d == S_IDLE);
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          instr_d = in_instr;
          alu_a_d = regs_q[in_rs1];
`ifdef ALU_IMM_OPB_EN
          alu_b_d = in_instr[0] ? in_imm : regs_q[in_rs2];
`else
          alu_b_d = regs_q[in_rs2];
`endif
        end else if (dbg_we && (dbg_addr != '0)) begin
          regs_d[dbg_addr] = dbg_wdata;
        end
      end
      S_EXEC: begin
        if (wb_rd != '0) regs_d[wb_rd] = alu_res;
        status_d = alu_flag;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_q  <= '0;
      status_q <= '0;
      done_q   <= 1'b0;
      ready_q  <= 1'b1;
      alu_a_q  <= '0;
      alu_b_q  <= '0;
      for (int i = 0; i < int'(NREG); i++) regs_q[i] <= '0;
    end else begin
      instr_q  <= instr_d;
      status_q <= status_d;
      done_q   <= done_d;
      ready_q  <= ready_d;
      alu_a_q  <= alu_a_d;
      alu_b_q  <= alu_b_d;
      regs_q   <= regs_d;
    end
  end

  assign in_ready  = ready_q;
  assign done      = done_q;
  assign status    = status_q;
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_op    = instr_q[15:12];
  assign dbg_rdata = (dbg_addr == '0) ? '0 : regs_q[dbg_addr];

  // Instruction bits not needed after accept (operands already captured)
`ifdef ALU_IMM_OPB_EN
  assign unused_bits = ^{instr_q[8:0], in_instr[2:1]};
`else
  assign unused_bits = ^{instr_q[8:0], in_instr[2:0], in_imm};
`endif

endmodule

// File: tb/tb_alu_issue_wb.sv
// Bench for alu_issue_wb: behavioural ALU on the alu_* ports, vector table plus hand-written corner sequences.
// Expectations follow `define ALU_IMM_OPB_EN when it is defined.
module tb_alu_issue_wb;

  logic        clk, rst;
  logic        in_valid, in_ready;
  logic [15:0] in_instr;
  logic [7:0]  in_imm, alu_a, alu_b, alu_res, alu_flag, status;
  logic [3:0]  alu_op;
  logic        done, dbg_we;
  logic [2:0]  dbg_addr;
  logic [7:0]  dbg_wdata, dbg_rdata;

  alu_issue_wb #(.DW(8), .NREG(8), .AW(3)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_imm(in_imm), .alu_a(alu_a), .alu_b(alu_b),
    .alu_op(alu_op), .alu_res(alu_res), .alu_flag(alu_flag), .status(status),
    .done(done), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_rdata(dbg_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU; flag byte = {op, 1, res[7], carry, zero}
  logic [8:0]  wide;
  logic [15:0] rot;
  logic        carry;
  always_comb begin
    wide    = '0;
    rot     = '0;
    carry   = 1'b0;
    alu_res = '0;
    case (alu_op[2:0])
      3'b000: begin
        wide    = alu_op[3] ? ({1'b0, alu_a} - {1'b0, alu_b}) : ({1'b0, alu_a} + {1'b0, alu_b});
        alu_res = wide[7:0];
        carry   = wide[8];
      end
      3'b001: alu_res = alu_a ^ alu_b;
      3'b010: alu_res = alu_a & alu_b;
      3'b011: alu_res = alu_op[3] ? ~(alu_a | alu_b) : (alu_a | alu_b);
      3'b100: alu_res = alu_a << alu_b[2:0];
      3'b101: alu_res = alu_a >> alu_b[2:0];
      3'b110: begin rot = {alu_a, alu_a} << alu_b[2:0]; alu_res = rot[15:8]; end
      default: begin rot = {alu_a, alu_a} >> alu_b[2:0]; alu_res = rot[7:0]; end
    endcase
    alu_flag = {alu_op, 1'b1, alu_res[7], carry, (alu_res == 8'h00)};
  end

  typedef struct {
    logic [3:0] op;
    logic [2:0] rd, rs1, rs2;
    logic       isel;
    logic [7:0] imm, ea, eb, eres, eflag;
  } vec_t;

  typedef struct {
    logic [2:0] rd;
    logic [7:0] res;
    logic [7:0] flag;
  } exp_t;

  exp_t sb[$];
  exp_t last;
  int   n_cmp = 0;
  int   n_bad = 0;
  vec_t vecs [15];

`ifdef ALU_IMM_OPB_EN
  localparam logic [7:0] IMM_B = 8'd200, IMM_RES = 8'hD2, IMM_FLG = 8'h0C;
`else
  localparam logic [7:0] IMM_B = 8'd5,   IMM_RES = 8'h0F, IMM_FLG = 8'h08;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: pop one expected writeback per done pulse
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (sb.size() == 0) begin
        chk("spurious_done", 32'd1, 32'd0);
      end else begin
        last = sb.pop_front();
        chk("status", 32'(status), 32'(last.flag));
      end
    end
  end

  function automatic logic [15:0] mk(input logic [3:0] op, input logic [2:0] rd, rs1, rs2,
                                     input logic isel);
    return {op, rd, rs1, rs2, 2'b00, isel};
  endfunction

  task automatic dbg_wr(input logic [2:0] a, input logic [7:0] d);
    @(negedge clk);
    dbg_we = 1'b1; dbg_addr = a; dbg_wdata = d;
    @(negedge clk);
    dbg_we = 1'b0;
  endtask

  task automatic dbg_chk(input string name, input logic [2:0] a, input logic [7:0] exp);
    dbg_addr = a;
    #1;
    chk(name, 32'(dbg_rdata), 32'(exp));
  endtask

  task automatic issue(input vec_t v);
    int n;
    exp_t e;
    @(negedge clk);
    chk("ready_idle", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_instr = mk(v.op, v.rd, v.rs1, v.rs2, v.isel);
    in_imm   = v.imm;
    e.rd = v.rd; e.res = v.eres; e.flag = v.eflag;
    sb.push_back(e);
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    chk("alu_a", 32'(alu_a), 32'(v.ea));
    chk("alu_b", 32'(alu_b), 32'(v.eb));
    chk("alu_op", 32'(alu_op), 32'(v.op));
    chk("ready_exec", 32'(in_ready), 32'd0);
    chk("done_exec", 32'(done), 32'd0);
    n = 0;
    while (done !== 1'b1 && n < 4) begin
      @(negedge clk);
      n++;
    end
    chk("done_latency", 32'(n), 32'd1);
    chk("ready_wb", 32'(in_ready), 32'd0);
    #1;
    dbg_chk("wb_reg", v.rd, (v.rd == 3'd0) ? 8'h00 : v.eres);
    @(negedge clk);
    chk("done_pulse_end", 32'(done), 32'd0);
    chk("ready_back", 32'(in_ready), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int acc, first, second, busy, n;
    exp_t e;

    vecs[0]  = '{4'b0000, 3'd3, 3'd1, 3'd2, 1'b0, 8'h00, 8'h0A, 8'h05, 8'h0F, 8'h08};
    vecs[1]  = '{4'b1000, 3'd4, 3'd2, 3'd1, 1'b0, 8'h00, 8'h05, 8'h0A, 8'hFB, 8'h8E};
    vecs[2]  = '{4'b0011, 3'd0, 3'd1, 3'd2, 1'b0, 8'h00, 8'h0A, 8'h05, 8'h0F, 8'h38};
    vecs[3]  = '{4'b0000, 3'd5, 3'd1, 3'd2, 1'b1, 8'd200, 8'h0A, IMM_B, IMM_RES, IMM_FLG};
    vecs[4]  = '{4'b0001, 3'd5, 3'd3, 3'd4, 1'b0, 8'h00, 8'h0F, 8'hFB, 8'hF4, 8'h1C};
    vecs[5]  = '{4'b0010, 3'd6, 3'd6, 3'd7, 1'b0, 8'h00, 8'h81, 8'hF0, 8'h80, 8'h2C};
    vecs[6]  = '{4'b1011, 3'd7, 3'd1, 3'd2, 1'b0, 8'h00, 8'h0A, 8'h05, 8'hF0, 8'hBC};
    vecs[7]  = '{4'b0100, 3'd5, 3'd1, 3'd2, 1'b0, 8'h00, 8'h0A, 8'h05, 8'h40, 8'h48};
    vecs[8]  = '{4'b0101, 3'd5, 3'd7, 3'd2, 1'b0, 8'h00, 8'hF0, 8'h05, 8'h07, 8'h58};
    vecs[9]  = '{4'b0110, 3'd5, 3'd6, 3'd2, 1'b0, 8'h00, 8'h80, 8'h05, 8'h10, 8'h68};
    vecs[10] = '{4'b0111, 3'd5, 3'd4, 3'd1, 1'b0, 8'h00, 8'hFB, 8'h0A, 8'hFE, 8'h7C};
    vecs[11] = '{4'b0000, 3'd2, 3'd2, 3'd2, 1'b0, 8'h00, 8'h05, 8'h05, 8'h0A, 8'h08};
    vecs[12] = '{4'b1000, 3'd3, 3'd2, 3'd1, 1'b0, 8'h00, 8'h0A, 8'h0A, 8'h00, 8'h89};
    vecs[13] = '{4'b0000, 3'd3, 3'd4, 3'd7, 1'b0, 8'h00, 8'hFB, 8'hF0, 8'hEB, 8'h0E};
    vecs[14] = '{4'b1001, 3'd4, 3'd6, 3'd7, 1'b0, 8'h00, 8'h80, 8'hF0, 8'h70, 8'h98};

    rst = 1'b1; in_valid = 1'b0; in_instr = '0; in_imm = '0;
    dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;
    #3;
    chk("rst_ready", 32'(in_ready), 32'd1);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_status", 32'(status), 32'd0);
    chk("rst_alu", 32'({alu_a, alu_b, alu_op}), 32'd0);
    dbg_chk("rst_r1", 3'd1, 8'h00);
    #9 rst = 1'b0;

    dbg_wr(3'd1, 8'd10);
    dbg_wr(3'd2, 8'd5);
    dbg_wr(3'd6, 8'h81);
    dbg_wr(3'd7, 8'hF0);
    dbg_wr(3'd0, 8'hAA);
    dbg_chk("dbg_r1", 3'd1, 8'd10);
    dbg_chk("dbg_r2", 3'd2, 8'd5);
    dbg_chk("dbg_r0_drop", 3'd0, 8'h00);

    for (int i = 0; i < 15; i++) issue(vecs[i]);
    dbg_chk("r7_after_nor", 3'd7, 8'hF0);

    // in_valid held high across two instructions
    @(negedge clk);
    in_valid = 1'b1;
    in_instr = mk(4'b0000, 3'd6, 3'd1, 3'd2, 1'b0);
    e.rd = 3'd6; e.res = 8'h14; e.flag = 8'h08; sb.push_back(e);
    acc = 0; first = -1; second = -1; busy = 0;
    for (int c = 0; c < 12 && acc < 2; c++) begin
      if (in_ready) begin
        if (acc == 0) first = c; else second = c;
        acc++;
      end else begin
        busy++;
      end
      @(posedge clk);
      #1;
      if (acc == 1 && busy == 0) begin
        in_instr = mk(4'b0001, 3'd7, 3'd6, 3'd1, 1'b0);
        e.rd = 3'd7; e.res = 8'h1E; e.flag = 8'h18; sb.push_back(e);
      end
      if (acc == 2) in_valid = 1'b0;
      @(negedge clk);
    end
    chk("b2b_spacing", 32'(second - first), 32'd3);
    chk("b2b_busy", 32'(busy), 32'd2);
    n = 0;
    while (sb.size() != 0 && n < 8) begin @(negedge clk); n++; end
    chk("b2b_drain", 32'(sb.size()), 32'd0);
    @(negedge clk);
    dbg_chk("b2b_r6", 3'd6, 8'h14);
    dbg_chk("b2b_r7", 3'd7, 8'h1E);

    // debug write together with accept, and held through EXEC/WB: dropped
    @(negedge clk);
    in_valid = 1'b1; in_instr = mk(4'b0000, 3'd3, 3'd1, 3'd2, 1'b0);
    dbg_we = 1'b1; dbg_addr = 3'd4; dbg_wdata = 8'h55;
    e.rd = 3'd3; e.res = 8'h14; e.flag = 8'h08; sb.push_back(e);
    @(posedge clk);
    #1 in_valid = 1'b0;
    n = 0;
    while (done !== 1'b1 && n < 5) begin @(negedge clk); n++; end
    chk("dbgconf_done", 32'(n), 32'd2);
    #1 dbg_we = 1'b0;
    @(negedge clk);
    dbg_chk("dbgconf_r4", 3'd4, 8'h70);
    dbg_chk("dbgconf_r3", 3'd3, 8'h14);

    // reset during EXEC aborts the instruction
    @(negedge clk);
    in_valid = 1'b1; in_instr = mk(4'b0000, 3'd3, 3'd1, 3'd2, 1'b0);
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_ready", 32'(in_ready), 32'd1);
    chk("abort_status", 32'(status), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    #1 rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("abort_no_done", 32'(done), 32'd0);
    end
    dbg_chk("abort_r3", 3'd3, 8'h00);
    dbg_chk("abort_r1", 3'd1, 8'h00);
    chk("abort_ready_idle", 32'(in_ready), 32'd1);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
